// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM: IDLE picks a winner, ACCESS runs the memory cycle(s),
  // DONE returns the one-cycle ack.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  // Grant encoding, also the select value for the address/wdata muxes.
  localparam logic GRANT_CORE = 1'b0;
  localparam logic GRANT_SPI  = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/mux_2X1.sv
// Generic 2:1 multiplexer; Sel=0 passes in0_i, Sel=1 passes in1_i.
module mux_2X1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             Sel,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = Sel ? in1_i : in0_i;

endmodule : mux_2X1

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core and the SPI loader/debug path.
// Round-robin on contention, one access of MEM_LAT cycles per grant, then a
// one-cycle ack to the winner. Read data is registered and shared.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // A zero-latency memory cannot be sequenced by this FSM.
  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end

  localparam int              CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  arb_state_e        state_q, state_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant;

  // Next-state logic: arbitration in IDLE, latency count in ACCESS.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    sel_d        = sel_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    grant        = GRANT_CORE;
    case (state_q)
      ST_IDLE: begin
        if (core_req || spi_req) begin
          // On a tie the side that did not win last time goes next.
          grant        = (core_req && spi_req) ? ~last_grant_q : spi_req;
          sel_d        = grant;
          we_d         = (grant == GRANT_SPI) ? spi_we : core_we;
          cnt_d        = '0;
          last_grant_d = grant;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; last_grant resets to SPI so the core wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= GRANT_CORE;
      we_q         <= 1'b0;
      last_grant_q <= GRANT_SPI;
      cnt_q        <= '0;
      rdata_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free
  // and all read zero in reset.
  assign mem_en   = (state_q == ST_ACCESS);
  assign mem_we   = mem_en && we_q && (cnt_q == '0);
  assign core_ack = (state_q == ST_DONE) && (sel_q == GRANT_CORE);
  assign spi_ack  = (state_q == ST_DONE) && (sel_q == GRANT_SPI);
  assign rdata    = rdata_q;
  assign sel      = sel_q;

  mux_2X1 #(.WIDTH(ADDR_W)) u_addr_mux (
    .in0_i (core_addr),
    .in1_i (spi_addr),
    .Sel   (sel_q),
    .out_o (mem_addr)
  );

  mux_2X1 #(.WIDTH(DATA_W)) u_wdata_mux (
    .in0_i (core_wdata),
    .in1_i (spi_wdata),
    .Sel   (sel_q),
    .out_o (mem_wdata)
  );

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 and one
// with MEM_LAT=3 sharing the requester stimulus, each with its own reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst1_n, rst3_n;
  logic        core_req, core_we, spi_req, spi_we;
  logic [31:0] core_addr, core_wdata, spi_addr, spi_wdata, mem_rdata;

  logic        l1_core_ack, l1_spi_ack, l1_sel, l1_mem_en, l1_mem_we;
  logic [31:0] l1_rdata, l1_mem_addr, l1_mem_wdata;
  logic        l3_core_ack, l3_spi_ack, l3_sel, l3_mem_en, l3_mem_we;
  logic [31:0] l3_rdata, l3_mem_addr, l3_mem_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst1_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(l1_core_ack),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_ack(l1_spi_ack),
    .rdata(l1_rdata), .sel(l1_sel), .mem_en(l1_mem_en), .mem_we(l1_mem_we),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst3_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(l3_core_ack),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_ack(l3_spi_ack),
    .rdata(l3_rdata), .sel(l3_sel), .mem_en(l3_mem_en), .mem_we(l3_mem_we),
    .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit run_l1, input bit run_l3);
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    spi_req  = 0; spi_we  = 0; spi_addr  = '0; spi_wdata  = '0;
    mem_rdata = '0;
    rst1_n = 0; rst3_n = 0;
    tick(); tick();
    rst1_n = run_l1; rst3_n = run_l3;
  endtask

  // Waits on the MEM_LAT=3 instance for an ack; n = cycles advanced.
  task automatic wait_ack(input string tag, output int n, output logic c, output logic s);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick(); n++;
      if (l3_core_ack || l3_spi_ack) break;
    end
    c = l3_core_ack; s = l3_spi_ack;
    total++;
    if (!(c || s)) begin bad++; $display("FAIL %s_timeout: no ack after %0d cycles", tag, n); end
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    total++; if ({l1_core_ack, l1_spi_ack, l1_mem_en, l1_mem_we, l1_sel} !== 5'b0) begin bad++; $display("FAIL rst_l1_ctrl: got %b want 00000", {l1_core_ack, l1_spi_ack, l1_mem_en, l1_mem_we, l1_sel}); end
    total++; if ({l3_core_ack, l3_spi_ack, l3_mem_en, l3_mem_we, l3_sel} !== 5'b0) begin bad++; $display("FAIL rst_l3_ctrl: got %b want 00000", {l3_core_ack, l3_spi_ack, l3_mem_en, l3_mem_we, l3_sel}); end
    total++; if (l1_rdata !== 32'h0) begin bad++; $display("FAIL rst_l1_rdata: got %h want 0", l1_rdata); end
    total++; if (l3_rdata !== 32'h0) begin bad++; $display("FAIL rst_l3_rdata: got %h want 0", l3_rdata); end
  endtask

  task automatic test_core_read_l1();
    do_reset(1'b1, 1'b0);
    core_we = 0; core_addr = 32'h10; mem_rdata = 32'hDEADBEEF; core_req = 1;
    tick(); // cycle 1
    total++; if (l1_mem_en !== 1'b1) begin bad++; $display("FAIL rd_c1_en: got %b want 1", l1_mem_en); end
    total++; if (l1_mem_we !== 1'b0) begin bad++; $display("FAIL rd_c1_we: got %b want 0", l1_mem_we); end
    total++; if (l1_mem_addr !== 32'h10) begin bad++; $display("FAIL rd_c1_addr: got %h want 10", l1_mem_addr); end
    total++; if (l1_core_ack !== 1'b0) begin bad++; $display("FAIL rd_c1_ack: got %b want 0", l1_core_ack); end
    tick(); // cycle 2
    total++; if (l1_core_ack !== 1'b1) begin bad++; $display("FAIL rd_c2_ack: got %b want 1", l1_core_ack); end
    total++; if (l1_spi_ack !== 1'b0) begin bad++; $display("FAIL rd_c2_spi_ack: got %b want 0", l1_spi_ack); end
    total++; if (l1_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_c2_rdata: got %h want deadbeef", l1_rdata); end
    total++; if (l1_sel !== 1'b0) begin bad++; $display("FAIL rd_c2_sel: got %b want 0", l1_sel); end
    total++; if (l1_mem_en !== 1'b0) begin bad++; $display("FAIL rd_c2_en: got %b want 0", l1_mem_en); end
    core_req = 0;
    tick(); // cycle 3, IDLE
    total++; if ({l1_core_ack, l1_spi_ack, l1_mem_en} !== 3'b0) begin bad++; $display("FAIL rd_c3_idle: got %b want 000", {l1_core_ack, l1_spi_ack, l1_mem_en}); end
  endtask

  task automatic test_spi_write();
    int we_cnt;
    do_reset(1'b0, 1'b1);
    spi_we = 1; spi_addr = 32'h20; spi_wdata = 32'h12345678; mem_rdata = 32'hCAFEF00D;
    spi_req = 1;
    tick(); // cycle 1
    total++; if (l3_mem_we !== 1'b1) begin bad++; $display("FAIL wr_c1_we: got %b want 1", l3_mem_we); end
    total++; if (l3_mem_addr !== 32'h20) begin bad++; $display("FAIL wr_c1_addr: got %h want 20", l3_mem_addr); end
    total++; if (l3_mem_wdata !== 32'h12345678) begin bad++; $display("FAIL wr_c1_wdata: got %h want 12345678", l3_mem_wdata); end
    total++; if (l3_sel !== 1'b1) begin bad++; $display("FAIL wr_c1_sel: got %b want 1", l3_sel); end
    we_cnt = 0;
    for (int i = 2; i <= 3; i++) begin
      tick();
      we_cnt += int'(l3_mem_we);
      total++; if (l3_mem_en !== 1'b1) begin bad++; $display("FAIL wr_c%0d_en: got %b want 1", i, l3_mem_en); end
    end
    total++; if (we_cnt != 0) begin bad++; $display("FAIL wr_extra_we: got %0d extra strobes want 0", we_cnt); end
    total++; if (l3_spi_ack !== 1'b0) begin bad++; $display("FAIL wr_c3_ack: got %b want 0", l3_spi_ack); end
    tick(); // cycle 4
    total++; if ({l3_spi_ack, l3_core_ack} !== 2'b10) begin bad++; $display("FAIL wr_c4_acks: got %b want 10", {l3_spi_ack, l3_core_ack}); end
    total++; if (l3_rdata !== 32'h0) begin bad++; $display("FAIL wr_c4_rdata: got %h want 0", l3_rdata); end
    spi_req = 0; spi_we = 0;
    tick();
    total++; if (l3_spi_ack !== 1'b0) begin bad++; $display("FAIL wr_c5_ack: got %b want 0", l3_spi_ack); end
  endtask

  task automatic test_round_robin();
    int n; logic c, s;
    do_reset(1'b0, 1'b1);
    core_addr = 32'h100; spi_addr = 32'h200; core_req = 1; spi_req = 1;
    for (int k = 0; k < 4; k++) begin
      wait_ack("rr", n, c, s);
      total++; if ({c, s} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_grant%0d: got core/spi=%b%b want %s", k, c, s, (k % 2 == 0) ? "core" : "spi"); end
      total++; if (n != ((k == 0) ? 4 : 5)) begin bad++; $display("FAIL rr_period%0d: got %0d cycles want %0d", k, n, (k == 0) ? 4 : 5); end
    end
    core_req = 0; spi_req = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int n, acks; logic c, s;
    do_reset(1'b0, 1'b1);
    spi_we = 0; spi_addr = 32'h40; mem_rdata = 32'h55AA55AA; spi_req = 1;
    wait_ack("rm", n, c, s);
    total++; if (l3_rdata !== 32'h55AA55AA) begin bad++; $display("FAIL rm_rdata_pre: got %h want 55aa55aa", l3_rdata); end
    tick(); // IDLE, re-grant to SPI
    tick(); // first ACCESS
    total++; if ({l3_mem_en, l3_sel} !== 2'b11) begin bad++; $display("FAIL rm_access: got en/sel=%b want 11", {l3_mem_en, l3_sel}); end
    tick(); // second ACCESS
    rst3_n = 0; spi_req = 0;
    #1;
    total++; if ({l3_mem_en, l3_sel, l3_core_ack, l3_spi_ack} !== 4'b0) begin bad++; $display("FAIL rm_async: got en/sel/acks=%b want 0000", {l3_mem_en, l3_sel, l3_core_ack, l3_spi_ack}); end
    total++; if (l3_rdata !== 32'h0) begin bad++; $display("FAIL rm_rdata: got %h want 0", l3_rdata); end
    tick();
    rst3_n = 1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acks += int'(l3_core_ack) + int'(l3_spi_ack) + int'(l3_mem_en);
    end
    total++; if (acks != 0) begin bad++; $display("FAIL rm_quiet: got %0d ack/en cycles want 0", acks); end
  endtask

  task automatic test_drop_req();
    int en_cnt, ack_cnt;
    do_reset(1'b0, 1'b1);
    core_we = 0; core_addr = 32'h80; mem_rdata = 32'h0BADF00D; core_req = 1;
    tick(); // cycle 1
    core_req = 0;
    en_cnt = int'(l3_mem_en); ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      en_cnt  += int'(l3_mem_en);
      ack_cnt += int'(l3_core_ack);
    end
    total++; if (ack_cnt != 1) begin bad++; $display("FAIL drop_acks: got %0d want 1", ack_cnt); end
    total++; if (en_cnt != 3) begin bad++; $display("FAIL drop_en_cycles: got %0d want 3", en_cnt); end
    total++; if (l3_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL drop_rdata: got %h want 0badf00d", l3_rdata); end
  endtask

  task automatic test_back_to_back();
    int n; logic c, s;
    do_reset(1'b0, 1'b1);
    core_we = 0; core_addr = 32'h100; mem_rdata = 32'h11111111; core_req = 1;
    wait_ack("b2b1", n, c, s);
    total++; if (n != 4 || c !== 1'b1) begin bad++; $display("FAIL b2b_first: got n=%0d core_ack=%b want n=4 core_ack=1", n, c); end
    total++; if (l3_rdata !== 32'h11111111) begin bad++; $display("FAIL b2b_rdata1: got %h want 11111111", l3_rdata); end
    mem_rdata = 32'h22222222;
    wait_ack("b2b2", n, c, s);
    total++; if (n != 5 || c !== 1'b1) begin bad++; $display("FAIL b2b_second: got n=%0d core_ack=%b want n=5 core_ack=1", n, c); end
    total++; if (l3_rdata !== 32'h22222222) begin bad++; $display("FAIL b2b_rdata2: got %h want 22222222", l3_rdata); end
    core_req = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_core_read_l1();
    test_spi_write();
    test_round_robin();
    test_reset_mid();
    test_drop_req();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
